jtag_tap_target: RTL and testbench



---
 rtl/flexsoc_jtag_pkg.sv | 54 +++++
 rtl/jtag_edge_sync.sv | 37 +++
 rtl/jtag_tap_target.sv | 123 ++++++++++++
 tb/tb_jtag_tap_target.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/flexsoc_jtag_pkg.sv
// Shared JTAG TAP definitions: state encoding, instruction codes and the
// IEEE 1149.1 next-state function.
package flexsoc_jtag_pkg;

    localparam int unsigned DR_W = 32;

    localparam logic [3:0] IR_IDCODE  = 4'b1110;
    localparam logic [3:0] IR_BYPASS  = 4'b1111;
    localparam logic [3:0] IR_SCRATCH = 4'b1000;
    localparam logic [3:0] IR_CAPTURE = 4'b0001;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR  = 4'h0,
        TAP_EXIT1_DR  = 4'h1,
        TAP_SHIFT_DR  = 4'h2,
        TAP_PAUSE_DR  = 4'h3,
        TAP_SEL_IR    = 4'h4,
        TAP_UPDATE_DR = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SEL_DR    = 4'h7,
        TAP_EXIT2_IR  = 4'h8,
        TAP_EXIT1_IR  = 4'h9,
        TAP_SHIFT_IR  = 4'hA,
        TAP_PAUSE_IR  = 4'hB,
        TAP_RTI       = 4'hC,
        TAP_UPDATE_IR = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_TLR       = 4'hF
    } tap_state_t;

    // Standard TAP transition on a TCK rising edge
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TAP_TLR:        return tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:        return tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_DR:     return tms ? TAP_SEL_IR    : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   return tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   return tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   return tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  return tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_IR:     return tms ? TAP_TLR       : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   return tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   return tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   return tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  return tms ? TAP_SEL_DR    : TAP_RTI;
            default:        return TAP_TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// Brings TCK/TMS/TDI into the CLK domain and derives one-CLK TCK edge strobes.
module jtag_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tms_s,
    output logic tdi_s,
    output logic rise_c,
    output logic fall
);

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic       tck_d;

    // All three pins share the same two flops so TMS/TDI stay aligned to TCK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            tck_d <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= {tdi, tms, tck};
            sync2 <= sync1;
            tck_d <= sync2[0];
            fall  <= ~sync2[0] & tck_d;
        end
    end

    assign rise_c = sync2[0] & ~tck_d;
    assign tms_s  = sync2[1];
    assign tdi_s  = sync2[2];

endmodule

// File: rtl/jtag_tap_target.sv
// JTAG TAP responder with IDCODE, BYPASS and a 32-bit SCRATCH data register,
// running entirely in the CLK domain from oversampled TCK.
module jtag_tap_target
    import flexsoc_jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE = 32'h1BEEF001,
    parameter int unsigned IR_LEN = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TCK,
    input  logic        TMS,
    input  logic        TDI,
    output logic        TDO,
    output logic        TDO_OE,
    output logic [3:0]  TAP_STATE,
    output logic [3:0]  IR,
    output logic [31:0] SCRATCH,
    output logic        DR_UPDATE
);

    tap_state_t          state;
    tap_state_t          state_next;
    logic                tms_s;
    logic                tdi_s;
    logic                rise_c;
    logic                fall;
    logic [IR_LEN-1:0]   ir_sr;
    logic [3:0]          ir;
    logic [DR_W-1:0]     dr_sr;
    logic [DR_W-1:0]     scratch;
    logic                tdo;
    logic                tdo_oe;
    logic                dr_update;
    logic                dr_long_c;

    jtag_edge_sync u_sync (
        .clk    (CLK),
        .rst    (RESET),
        .tck    (TCK),
        .tms    (TMS),
        .tdi    (TDI),
        .tms_s  (tms_s),
        .tdi_s  (tdi_s),
        .rise_c (rise_c),
        .fall   (fall)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= TAP_TLR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rise_c) state_next = tap_next(state, tms_s);
    end

    // Instruction path: capture/shift act on the current state, update on entry
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ir_sr <= '0;
            ir    <= IR_IDCODE;
        end else if (rise_c) begin
            case (state)
                TAP_CAPTURE_IR: ir_sr <= IR_LEN'(IR_CAPTURE);
                TAP_SHIFT_IR:   ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
                default:        ir_sr <= ir_sr;
            endcase
            if (state_next == TAP_UPDATE_IR) ir <= 4'(ir_sr);
            else if (state_next == TAP_TLR)  ir <= IR_IDCODE;
        end
    end

    assign dr_long_c = (ir == IR_IDCODE) || (ir == IR_SCRATCH);

    // Data path; bypass uses only bit 0 of the shared shift register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dr_sr     <= '0;
            scratch   <= '0;
            dr_update <= 1'b0;
        end else begin
            dr_update <= 1'b0;
            if (rise_c) begin
                case (state)
                    TAP_CAPTURE_DR: begin
                        if (ir == IR_IDCODE)       dr_sr <= IDCODE;
                        else if (ir == IR_SCRATCH) dr_sr <= scratch;
                        else                       dr_sr <= '0;
                    end
                    TAP_SHIFT_DR: begin
                        if (dr_long_c) dr_sr <= {tdi_s, dr_sr[DR_W-1:1]};
                        else           dr_sr <= {dr_sr[DR_W-1:1], tdi_s};
                    end
                    default: dr_sr <= dr_sr;
                endcase
                if (state_next == TAP_UPDATE_DR && ir == IR_SCRATCH) begin
                    scratch   <= dr_sr;
                    dr_update <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else if (fall) begin
            tdo    <= (state == TAP_SHIFT_IR) ? ir_sr[0] : dr_sr[0];
            tdo_oe <= (state == TAP_SHIFT_IR) || (state == TAP_SHIFT_DR);
        end
    end

    assign TDO       = tdo;
    assign TDO_OE    = tdo_oe;
    assign TAP_STATE = state;
    assign IR        = ir;
    assign SCRATCH   = scratch;
    assign DR_UPDATE = dr_update;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed bench for jtag_tap_target: drives slow TCK and checks TAP behaviour.
module tb_jtag_tap_target;
    import flexsoc_jtag_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        TCK;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        TDO_OE;
    logic [3:0]  TAP_STATE;
    logic [3:0]  IR;
    logic [31:0] SCRATCH;
    logic        DR_UPDATE;

    int n_cmp   = 0;
    int n_err   = 0;
    int upd_cnt = 0;

    jtag_tap_target #(.IDCODE(32'h1BEEF001), .IR_LEN(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .TDO_OE    (TDO_OE),
        .TAP_STATE (TAP_STATE),
        .IR        (IR),
        .SCRATCH   (SCRATCH),
        .DR_UPDATE (DR_UPDATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One TCK period: TDO/TDO_OE sampled just before the rising edge
    task automatic tck_bit(input logic tms_i, input logic tdi_i,
                           output logic tdo_o, output logic oe_o);
        @(negedge CLK);
        TMS   = tms_i;
        TDI   = tdi_i;
        tdo_o = TDO;
        oe_o  = TDO_OE;
        @(negedge CLK);
        TCK = 1'b1;
        repeat (8) begin @(negedge CLK); upd_cnt += int'(DR_UPDATE); end
        TCK = 1'b0;
        repeat (8) begin @(negedge CLK); upd_cnt += int'(DR_UPDATE); end
    endtask

    task automatic tms_seq(input logic [7:0] seq, input int n);
        logic t, o;
        for (int i = 0; i < n; i++) tck_bit(seq[i], 1'b0, t, o);
    endtask

    // From Run-Test/Idle through a full DR scan, back to Run-Test/Idle
    task automatic shift_dr(input logic [31:0] din, input int n,
                            output logic [31:0] dout, output logic oe_during,
                            output logic oe_after);
        logic t, o;
        upd_cnt   = 0;
        dout      = '0;
        oe_during = 1'b1;
        tms_seq(8'b001, 3);
        for (int i = 0; i < n; i++) begin
            tck_bit(i == n - 1, din[i], t, o);
            dout[i]   = t;
            oe_during = oe_during & o;
        end
        oe_after = TDO_OE;
        tms_seq(8'b01, 2);
    endtask

    task automatic shift_ir(input logic [3:0] din, output logic [3:0] dout);
        logic t, o;
        tms_seq(8'b0011, 4);
        for (int i = 0; i < 4; i++) begin
            tck_bit(i == 3, din[i], t, o);
            dout[i] = t;
        end
        tms_seq(8'b01, 2);
    endtask

    logic [31:0] dout;
    logic [3:0]  iout;
    logic        oe_d, oe_a, t, o;

    initial begin
        RESET = 1'b1;
        TCK   = 1'b0;
        TMS   = 1'b0;
        TDI   = 1'b0;
        repeat (4) @(negedge CLK);
        chk("rst_state", 32'(TAP_STATE), 32'(TAP_TLR));
        chk("rst_ir", 32'(IR), 32'h0000000E);
        chk("rst_scratch", SCRATCH, 32'h0);
        chk("rst_tdo", 32'(TDO), 32'h0);
        chk("rst_oe", 32'(TDO_OE), 32'h0);
        chk("rst_upd", 32'(DR_UPDATE), 32'h0);
        RESET = 1'b0;

        // Four idle clocks settle in Run-Test/Idle
        for (int i = 0; i < 4; i++) begin
            tck_bit(1'b0, 1'b0, t, o);
            chk("idle_oe", 32'(TDO_OE), 32'h0);
        end
        chk("idle_state", 32'(TAP_STATE), 32'(TAP_RTI));
        chk("idle_ir", 32'(IR), 32'h0000000E);

        // IDCODE readout after reset
        shift_dr(32'h0, 32, dout, oe_d, oe_a);
        chk("idcode_data", dout, 32'h1BEEF001);
        chk("idcode_oe_during", 32'(oe_d), 32'h1);
        chk("idcode_oe_after", 32'(oe_a), 32'h0);
        chk("idcode_no_upd", 32'(upd_cnt), 32'h0);
        chk("idcode_state", 32'(TAP_STATE), 32'(TAP_RTI));

        // BYPASS: capture pattern out of IR, one-bit delay in DR
        shift_ir(4'b1111, iout);
        chk("ir_capture_out", 32'(iout), 32'h1);
        chk("ir_bypass", 32'(IR), 32'hF);
        shift_dr(32'b1101, 4, dout, oe_d, oe_a);
        chk("bypass_data", dout, 32'b1010);

        // Unlisted instruction code behaves as BYPASS
        shift_ir(4'b0101, iout);
        chk("ir_unlisted", 32'(IR), 32'h5);
        shift_dr(32'b11, 2, dout, oe_d, oe_a);
        chk("unlisted_bypass", dout, 32'b10);
        chk("unlisted_no_upd", 32'(upd_cnt), 32'h0);

        // SCRATCH write and read back
        shift_ir(4'b1000, iout);
        chk("ir_scratch", 32'(IR), 32'h8);
        shift_dr(32'hDEADBEEF, 32, dout, oe_d, oe_a);
        chk("scratch_written", SCRATCH, 32'hDEADBEEF);
        chk("scratch_upd_width", 32'(upd_cnt), 32'h1);
        shift_dr(32'h12345678, 32, dout, oe_d, oe_a);
        chk("scratch_readback", dout, 32'hDEADBEEF);
        chk("scratch_rewritten", SCRATCH, 32'h12345678);

        // Five TMS=1 clocks from Shift-DR reach Test-Logic-Reset
        shift_ir(4'b1111, iout);
        tms_seq(8'b001, 3);
        chk("at_shift_dr", 32'(TAP_STATE), 32'(TAP_SHIFT_DR));
        tms_seq(8'b11111, 5);
        chk("tlr_from_sdr", 32'(TAP_STATE), 32'(TAP_TLR));
        chk("tlr_ir_sdr", 32'(IR), 32'hE);

        // Same from Pause-IR
        tms_seq(8'b0, 1);
        shift_ir(4'b1111, iout);
        chk("ir_before_pause", 32'(IR), 32'hF);
        tms_seq(8'b010011, 6);
        chk("at_pause_ir", 32'(TAP_STATE), 32'(TAP_PAUSE_IR));
        tms_seq(8'b11111, 5);
        chk("tlr_from_pir", 32'(TAP_STATE), 32'(TAP_TLR));
        chk("tlr_ir_pir", 32'(IR), 32'hE);
        chk("tlr_keeps_scratch", SCRATCH, 32'h12345678);

        // RESET in the middle of a SCRATCH shift
        tms_seq(8'b0, 1);
        shift_ir(4'b1000, iout);
        tms_seq(8'b001, 3);
        for (int i = 0; i < 10; i++) tck_bit(1'b0, 1'b1, t, o);
        chk("mid_shift_oe", 32'(TDO_OE), 32'h1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("mid_rst_state", 32'(TAP_STATE), 32'(TAP_TLR));
        chk("mid_rst_ir", 32'(IR), 32'hE);
        chk("mid_rst_scratch", SCRATCH, 32'h0);
        chk("mid_rst_tdo", 32'(TDO), 32'h0);
        chk("mid_rst_oe", 32'(TDO_OE), 32'h0);
        chk("mid_rst_upd", 32'(DR_UPDATE), 32'h0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        tms_seq(8'b0, 1);
        shift_dr(32'h0, 32, dout, oe_d, oe_a);
        chk("post_rst_idcode", dout, 32'h1BEEF001);
        chk("post_rst_scratch", SCRATCH, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
